// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared state encoding and constants for the SCCB target
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        SUB,
        SUB_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } state_e;

    localparam logic       RW_WRITE     = 1'b0;
    localparam logic       RW_READ      = 1'b1;
    localparam logic [6:0] DEF_DEV_ADDR = 7'h21;

endpackage

// File: rtl/sccb_line_cond.sv
// rtl/sccb_line_cond.sv - SCL/SDA synchronizers with edge, START and STOP strobes
module sccb_line_cond (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    // [0],[1] form the synchronizer, [2] is the previous synced value.
    // Reset to the idle-bus level so release of reset produces no strobes.
    logic [2:0] scl_q;
    logic [2:0] sda_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign sda_o      = sda_q[1];
    assign scl_rise_o = scl_q[1] & ~scl_q[2];
    assign scl_fall_o = ~scl_q[1] & scl_q[2];
    assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - SCCB/I2C target responder with a 256x8 register file
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
    parameter bit         AUTO_INC = 1'b1
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data
);

    localparam logic [7:0] PTR_STEP = {7'd0, AUTO_INC};

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    sccb_line_cond u_line_cond (
        .clk_i      (Clk),
        .rst_ni     (reset_n),
        .scl_i      (scl),
        .sda_i      (sda_i),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start_det),
        .stop_o     (stop_det)
    );

    state_e     state_q;
    logic [2:0] cnt_q;
    logic [7:0] shreg_q;
    logic [7:0] ptr_q;
    logic       rw_q;
    logic       sda_oe_q;
    logic       wr_valid_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       busy_q;
    logic [7:0] regfile_q [256];

    logic [7:0] rx_byte;
    logic [7:0] rd_byte;

    assign rx_byte = {shreg_q[6:0], sda_s};
    assign rd_byte = regfile_q[ptr_q];

    // In ACK states cnt_q is a phase flag: 0 = waiting for the fall that
    // starts the ACK slot, 1 = waiting for the fall that ends it.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shreg_q    <= 8'h00;
            ptr_q      <= 8'h00;
            rw_q       <= RW_WRITE;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            for (int i = 0; i < 256; i++) regfile_q[i] <= 8'h00;
        end else begin
            wr_valid_q <= 1'b0;
            if (stop_det) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
                cnt_q    <= 3'd0;
            end else if (start_det) begin
                state_q <= ADDR;
                cnt_q   <= 3'd0;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (scl_rise) begin
                            shreg_q <= rx_byte;
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_q <= ADDR_ACK;
                                    busy_q  <= 1'b1;
                                    rw_q    <= rx_byte[0];
                                end else begin
                                    state_q <= IGNORE;
                                end
                            end
                        end else if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                        end
                    end
                    ADDR_ACK, SUB_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            if (cnt_q == 3'd0) begin
                                sda_oe_q <= 1'b1;
                                cnt_q    <= 3'd1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                cnt_q    <= 3'd0;
                                if (state_q == ADDR_ACK && rw_q == RW_READ) begin
                                    state_q  <= RD_DATA;
                                    sda_oe_q <= ~rd_byte[7];
                                    shreg_q  <= {rd_byte[6:0], 1'b0};
                                end else if (state_q == ADDR_ACK) begin
                                    state_q <= SUB;
                                end else if (state_q == SUB_ACK) begin
                                    state_q <= WR_DATA;
                                end else begin
                                    state_q <= WR_DATA;
                                    ptr_q   <= ptr_q + PTR_STEP;
                                end
                            end
                        end
                    end
                    SUB, WR_DATA: begin
                        if (scl_rise) begin
                            shreg_q <= rx_byte;
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7 && state_q == SUB) begin
                                ptr_q   <= rx_byte;
                                state_q <= SUB_ACK;
                            end else if (cnt_q == 3'd7) begin
                                regfile_q[ptr_q] <= rx_byte;
                                wr_valid_q       <= 1'b1;
                                wr_addr_q        <= ptr_q;
                                wr_data_q        <= rx_byte;
                                state_q          <= WR_ACK;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (cnt_q == 3'd7) begin
                                sda_oe_q <= 1'b0;
                                cnt_q    <= 3'd0;
                                state_q  <= RD_ACK;
                            end else begin
                                sda_oe_q <= ~shreg_q[7];
                                shreg_q  <= {shreg_q[6:0], 1'b0};
                                cnt_q    <= cnt_q + 3'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        // Next byte is fetched at the fall ending the ACK slot
                        // so SDA only moves while SCL is low.
                        if (scl_rise) begin
                            if (sda_s) begin
                                state_q <= IGNORE;
                            end else begin
                                ptr_q <= ptr_q + PTR_STEP;
                                cnt_q <= 3'd1;
                            end
                        end else if (scl_fall && cnt_q == 3'd1) begin
                            state_q  <= RD_DATA;
                            cnt_q    <= 3'd0;
                            sda_oe_q <= ~rd_byte[7];
                            shreg_q  <= {rd_byte[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign dbg_data = regfile_q[dbg_addr];

endmodule

// File: tb/tb_sccb_target.sv
// tb/tb_sccb_target.sv - scoreboard bench for sccb_target driven by a bit-level bus master
module tb_sccb_target;

    localparam int         Q     = 8;
    localparam logic [6:0] DEV_A = 7'h21;
    localparam logic [6:0] DEV_B = 7'h35;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m, sda_m;
    logic       bus_sda;
    logic       oe_a, oe_b, wv_a, wv_b, busy_a, busy_b;
    logic [7:0] wa_a, wd_a, wa_b, wd_b;
    logic [7:0] dbg_addr_a, dbg_addr_b, dbg_data_a, dbg_data_b;

    always #5 clk = ~clk;
    assign bus_sda = sda_m & ~oe_a & ~oe_b;

    sccb_target #(.DEV_ADDR(DEV_A), .AUTO_INC(1'b1)) u_dut_a (
        .Clk(clk), .reset_n(rst_n), .scl(scl_m), .sda_i(bus_sda), .sda_oe(oe_a),
        .wr_valid(wv_a), .wr_addr(wa_a), .wr_data(wd_a), .busy(busy_a),
        .dbg_addr(dbg_addr_a), .dbg_data(dbg_data_a)
    );

    sccb_target #(.DEV_ADDR(DEV_B), .AUTO_INC(1'b0)) u_dut_b (
        .Clk(clk), .reset_n(rst_n), .scl(scl_m), .sda_i(bus_sda), .sda_oe(oe_b),
        .wr_valid(wv_b), .wr_addr(wa_b), .wr_data(wd_b), .busy(busy_b),
        .dbg_addr(dbg_addr_b), .dbg_data(dbg_data_b)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];
    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];
    logic [7:0]  rd_exp [$];
    logic [7:0]  txq [$];
    logic [15:0] pop_a, pop_b;
    int          hi_cnt = 0;
    logic        oe_a_p = 1'b0, oe_b_p = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        @(negedge clk);
        b = bus_sda;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            get_bit(bt);
            d[i] = bt;
        end
        send_bit(nack);
    endtask

    // Model: target DEV_A advances the sub-address per byte, DEV_B holds it.
    task automatic do_write(input logic [6:0] dev, input logic [7:0] sub);
        logic       ack, exp_ack;
        logic [7:0] a;
        exp_ack = (dev == DEV_A || dev == DEV_B) ? 1'b0 : 1'b1;
        a = sub;
        foreach (txq[i]) begin
            if (dev == DEV_A) begin
                mem_a[a] = txq[i];
                exp_a.push_back({a, txq[i]});
                a = a + 8'd1;
            end else if (dev == DEV_B) begin
                mem_b[a] = txq[i];
                exp_b.push_back({a, txq[i]});
            end
        end
        bus_start();
        write_byte({dev, 1'b0}, ack);
        chk("addr_ack", ack, exp_ack);
        @(negedge clk);
        chk("busy_a_during", busy_a, dev == DEV_A);
        chk("busy_b_during", busy_b, dev == DEV_B);
        write_byte(sub, ack);
        chk("sub_ack", ack, exp_ack);
        foreach (txq[i]) begin
            write_byte(txq[i], ack);
            chk("data_ack", ack, exp_ack);
        end
        bus_stop();
        tick(4);
        @(negedge clk);
        chk("busy_a_after_stop", busy_a, 1'b0);
        chk("busy_b_after_stop", busy_b, 1'b0);
    endtask

    task automatic do_read(input logic [6:0] dev, input logic [7:0] sub, input int n);
        logic       ack;
        logic [7:0] a, d;
        a = sub;
        for (int i = 0; i < n; i++) begin
            rd_exp.push_back(dev == DEV_A ? mem_a[a] : mem_b[a]);
            if (dev == DEV_A) a = a + 8'd1;
        end
        bus_start();
        write_byte({dev, 1'b0}, ack);
        chk("rd_addr_w_ack", ack, 1'b0);
        write_byte(sub, ack);
        chk("rd_sub_ack", ack, 1'b0);
        bus_start();
        write_byte({dev, 1'b1}, ack);
        chk("rd_addr_r_ack", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            read_byte(d, (i == n - 1));
            chk("rd_data", d, rd_exp.pop_front());
        end
        tick(4);
        @(negedge clk);
        chk("sda_released_after_nack", {oe_a, oe_b}, 2'b00);
        bus_stop();
        tick(4);
    endtask

    always @(negedge clk) begin
        if (rst_n && wv_a) begin
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_a_unexpected: got %0h:%0h expected none", wa_a, wd_a);
            end else begin
                pop_a = exp_a.pop_front();
                chk("wr_a", {wa_a, wd_a}, pop_a);
            end
        end
        if (rst_n && wv_b) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_b_unexpected: got %0h:%0h expected none", wa_b, wd_b);
            end else begin
                pop_b = exp_b.pop_front();
                chk("wr_b", {wa_b, wd_b}, pop_b);
            end
        end
    end

    // SDA must hold steady once SCL has been high long enough to be seen synced.
    always @(negedge clk) begin
        hi_cnt = scl_m ? hi_cnt + 1 : 0;
        if (rst_n && hi_cnt > 4) begin
            chk("oe_a_stable_scl_high", oe_a, oe_a_p);
            chk("oe_b_stable_scl_high", oe_b, oe_b_p);
        end
        oe_a_p = oe_a;
        oe_b_p = oe_b;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] sub_r, b8;
    int         len_r, waited;

    initial begin
        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        dbg_addr_a = 8'h00; dbg_addr_b = 8'h00;
        for (int k = 0; k < 256; k++) begin mem_a[k] = 8'h00; mem_b[k] = 8'h00; end
        tick(3);
        @(negedge clk);
        chk("rst_oe", {oe_a, oe_b}, 2'b00);
        chk("rst_wv", {wv_a, wv_b}, 2'b00);
        chk("rst_wa_wd", {wa_a, wd_a, wa_b, wd_b}, 32'h0);
        chk("rst_busy", {busy_a, busy_b}, 2'b00);
        dbg_addr_a = 8'($urandom);
        #1;
        chk("rst_regfile", dbg_data_a, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);

        // Simple addressed write
        txq.delete(); txq.push_back(8'h80);
        do_write(DEV_A, 8'h12);
        dbg_addr_a = 8'h12; @(negedge clk);
        chk("dbg_after_write", dbg_data_a, mem_a[8'h12]);

        // Unaddressed frame: no ACK, no write
        do_write(7'h30, 8'h12);
        @(negedge clk);
        chk("dbg_unchanged", dbg_data_a, mem_a[8'h12]);

        // Write then repeated-START read
        txq.delete(); txq.push_back(8'h76);
        do_write(DEV_A, 8'h0A);
        do_read(DEV_A, 8'h0A, 1);

        // Burst wrapping past 0xFF, and the non-incrementing target
        txq.delete(); txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33);
        do_write(DEV_A, 8'hFE);
        do_read(DEV_A, 8'hFE, 3);
        do_write(DEV_B, 8'hFE);
        dbg_addr_b = 8'hFE; @(negedge clk);
        chk("hold_final", dbg_data_b, mem_b[8'hFE]);
        do_read(DEV_B, 8'hFE, 2);

        // STOP inside a data byte discards it
        begin
            logic ack;
            bus_start();
            write_byte({DEV_A, 1'b0}, ack);
            write_byte(8'h20, ack);
            b8 = 8'hA5;
            for (int i = 7; i >= 4; i--) send_bit(b8[i]);
            bus_stop();
            tick(4);
        end
        dbg_addr_a = 8'h20; @(negedge clk);
        chk("partial_no_write", dbg_data_a, mem_a[8'h20]);
        chk("partial_idle", {busy_a, oe_a}, 2'b00);
        txq.delete(); txq.push_back(8'h5C);
        do_write(DEV_A, 8'h20);
        @(negedge clk);
        chk("after_partial_write", dbg_data_a, mem_a[8'h20]);

        // Randomized write/read traffic to both targets
        for (int it = 0; it < 8; it++) begin
            logic [6:0] dev;
            dev   = ($urandom_range(0, 3) == 0) ? DEV_B : DEV_A;
            sub_r = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(253, 255)) : 8'($urandom);
            len_r = $urandom_range(1, 3);
            txq.delete();
            for (int j = 0; j < len_r; j++) txq.push_back(8'($urandom));
            do_write(dev, sub_r);
            do_read(dev, sub_r, $urandom_range(1, 3));
        end

        // Reset asserted while the target is driving the address ACK
        bus_start();
        b8 = {DEV_A, 1'b0};
        for (int i = 7; i >= 1; i--) send_bit(b8[i]);
        sda_m = b8[0]; tick(Q);
        scl_m = 1'b1;  tick(2 * Q);
        scl_m = 1'b0;
        waited = 0;
        while (!oe_a && waited < 3 * Q) begin @(negedge clk); waited++; end
        chk("ack_before_reset", oe_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_oe", {oe_a, oe_b}, 2'b00);
        chk("async_rst_outs", {wv_a, busy_a, wa_a, wd_a}, 18'h0);
        dbg_addr_a = 8'h12;
        #1;
        chk("async_rst_reg12", dbg_data_a, 8'h00);
        for (int k = 0; k < 256; k++) begin mem_a[k] = 8'h00; mem_b[k] = 8'h00; end
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        txq.delete(); txq.push_back(8'h9D); txq.push_back(8'h3E);
        do_write(DEV_A, 8'h12);
        do_read(DEV_A, 8'h12, 2);

        tick(20);
        chk("scoreboard_a_drained", exp_a.size(), 0);
        chk("scoreboard_b_drained", exp_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
